// File: rtl/decode_stage.sv
// Single-entry RV32I decode register: captures one instruction, registers its decoded bundle.
// Restricted ALU subset (ADD/SUB/XOR/OR/AND and immediate forms); everything else is flagged illegal.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_alu_funct3,
  output logic            out_alu_funct7,
  output logic [2:0]      out_funct3_raw,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [3:0]      out_opclass,
  output logic            out_reg_write,
  output logic            out_illegal
);

  localparam logic [3:0] OC_ALU_R   = 4'd0;
  localparam logic [3:0] OC_ALU_I   = 4'd1;
  localparam logic [3:0] OC_LOAD    = 4'd2;
  localparam logic [3:0] OC_STORE   = 4'd3;
  localparam logic [3:0] OC_BRANCH  = 4'd4;
  localparam logic [3:0] OC_JAL     = 4'd5;
  localparam logic [3:0] OC_JALR    = 4'd6;
  localparam logic [3:0] OC_LUI     = 4'd7;
  localparam logic [3:0] OC_AUIPC   = 4'd8;
  localparam logic [3:0] OC_ILLEGAL = 4'd15;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic        alu_op_ok;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]  dec_opclass;
  logic [31:0] dec_imm;
  logic [2:0]  dec_alu_f3;
  logic        dec_alu_f7;
  logic        dec_reg_write;

  logic            accept;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q;
  logic [2:0]      alu_f3_q, f3_raw_q;
  logic            alu_f7_q, reg_write_q, illegal_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [31:0]     imm_q;
  logic [3:0]      opclass_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  // Only ADD/XOR/OR/AND funct3 codes reach alu_control.
  assign alu_op_ok = (funct3 == 3'b000) || (funct3 == 3'b100) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    dec_opclass = OC_ILLEGAL;
    dec_imm     = '0;
    dec_alu_f3  = 3'b000;
    dec_alu_f7  = 1'b0;
    case (opcode)
      7'b0110011: begin
        if ((funct7 == 7'b0000000 && alu_op_ok) ||
            (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
          dec_opclass = OC_ALU_R;
          dec_alu_f3  = funct3;
          dec_alu_f7  = in_instr[30];
        end
      end
      7'b0010011: begin
        if (alu_op_ok) begin
          dec_opclass = OC_ALU_I;
          dec_imm     = imm_i;
          dec_alu_f3  = funct3;
        end
      end
      7'b0000011: begin dec_opclass = OC_LOAD;   dec_imm = imm_i; end
      7'b0100011: begin dec_opclass = OC_STORE;  dec_imm = imm_s; end
      7'b1100011: begin dec_opclass = OC_BRANCH; dec_imm = imm_b; end
      7'b1101111: begin dec_opclass = OC_JAL;    dec_imm = imm_j; end
      7'b1100111: begin dec_opclass = OC_JALR;   dec_imm = imm_i; end
      7'b0110111: begin dec_opclass = OC_LUI;    dec_imm = imm_u; end
      7'b0010111: begin dec_opclass = OC_AUIPC;  dec_imm = imm_u; end
      default: ;
    endcase
  end

  assign dec_reg_write = (rd != 5'd0) && (dec_opclass != OC_STORE) &&
                         (dec_opclass != OC_BRANCH) && (dec_opclass != OC_ILLEGAL);

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)
      valid_d = 1'b0;
    else if (accept)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;
  end

  // Fields load only on accept so a held bundle cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      alu_f3_q    <= '0;
      alu_f7_q    <= 1'b0;
      f3_raw_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      opclass_q   <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q        <= in_pc;
        alu_f3_q    <= dec_alu_f3;
        alu_f7_q    <= dec_alu_f7;
        f3_raw_q    <= funct3;
        rs1_q       <= in_instr[19:15];
        rs2_q       <= in_instr[24:20];
        rd_q        <= rd;
        imm_q       <= dec_imm;
        opclass_q   <= dec_opclass;
        reg_write_q <= dec_reg_write;
        illegal_q   <= (dec_opclass == OC_ILLEGAL);
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_alu_funct3 = alu_f3_q;
  assign out_alu_funct7 = alu_f7_q;
  assign out_funct3_raw = f3_raw_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_rd         = rd_q;
  assign out_imm        = imm_q;
  assign out_opclass    = opclass_q;
  assign out_reg_write  = reg_write_q;
  assign out_illegal    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: transaction-queue model with per-cycle compare plus directed literal checks.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [2:0]  out_alu_funct3, out_funct3_raw;
  logic        out_alu_funct7, out_reg_write, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_opclass;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_funct3(out_alu_funct3), .out_alu_funct7(out_alu_funct7),
    .out_funct3_raw(out_funct3_raw), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_opclass(out_opclass), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decoded bundle from the ISA rules: {opclass, alu_f3, alu_f7, f3_raw, rs1, rs2, rd, imm, rw, illegal, pc}
  function automatic logic [91:0] model(input logic [31:0] i, input logic [31:0] pc);
    logic [3:0]  cls;
    logic [31:0] imm;
    logic [2:0]  af3;
    logic        af7, rw;
    logic [9:0]  rkey;
    cls = 4'd15; imm = 32'd0; af3 = 3'd0; af7 = 1'b0;
    rkey = {i[31:25], i[14:12]};
    case (i[6:0])
      7'h33: if (rkey inside {10'h000, 10'h004, 10'h006, 10'h007, 10'h100}) begin
               cls = 4'd0; af3 = i[14:12]; af7 = i[30];
             end
      7'h13: if (i[14:12] inside {3'd0, 3'd4, 3'd6, 3'd7}) begin
               cls = 4'd1; af3 = i[14:12]; imm = 32'($signed(i[31:20]));
             end
      7'h03: begin cls = 4'd2; imm = 32'($signed(i[31:20])); end
      7'h23: begin cls = 4'd3; imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h63: begin cls = 4'd4; imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h6F: begin cls = 4'd5; imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h67: begin cls = 4'd6; imm = 32'($signed(i[31:20])); end
      7'h37: begin cls = 4'd7; imm = i & 32'hFFFF_F000; end
      7'h17: begin cls = 4'd8; imm = i & 32'hFFFF_F000; end
      default: ;
    endcase
    rw = (i[11:7] != 5'd0) && !(cls inside {4'd3, 4'd4, 4'd15});
    return {cls, af3, af7, i[14:12], i[19:15], i[24:20], i[11:7], imm, rw, cls == 4'd15, pc};
  endfunction

  logic [91:0] act_bundle;
  assign act_bundle = {out_opclass, out_alu_funct3, out_alu_funct7, out_funct3_raw,
                       out_rs1, out_rs2, out_rd, out_imm, out_reg_write, out_illegal, out_pc};

  logic [63:0] q[$];
  logic [31:0] drained[$];
  logic        rst_at_edge = 1'b0;

  always @(posedge clk) begin
    bit rdy;
    rst_at_edge <= rst;
    rdy = (q.size() == 0) || out_ready;
    if (rst || flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back({in_instr, in_pc});
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {95'd0, out_valid}, {95'd0, q.size() != 0});
    chk("in_ready", {95'd0, in_ready}, {95'd0, !flush && (q.size() == 0 || out_ready)});
    if (rst_at_edge) chk("reset_bundle", {4'd0, act_bundle}, 96'd0);
    else if (q.size() != 0) chk("bundle", {4'd0, act_bundle}, {4'd0, model(q[0][63:32], q[0][31:0])});
    if (out_valid && out_ready) drained.push_back(out_pc);
  end

  task automatic cyc(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    bit acc;
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    cyc(acc);
    in_valid = 1'b0;
  endtask

  logic [31:0] words [12] = '{32'hFE512E23, 32'hFE208CE3, 32'h000080E7, 32'h00001017,
                              32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h4020C1B3,
                              32'h0020A1B3, 32'h0010C093, 32'h00109093, 32'h00000000};
  logic [31:0] stream [4] = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3, 32'hFFF00093};

  initial begin
    bit acc;
    int idx, k;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h40;

    repeat (3) begin
      cyc(acc);
      chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
      chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
    end
    rst = 1'b0; in_valid = 1'b0;
    cyc(acc);
    chk("post_rst_nothing_captured", {95'd0, out_valid}, 96'd0);

    send(32'h002081B3, 32'h1000);
    chk("add_valid", {95'd0, out_valid}, 96'd1);
    chk("add_fields", {77'd0, out_opclass, out_alu_funct3, out_alu_funct7, out_rs1, out_rs2, out_rd, out_reg_write},
        {77'd0, 4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1});
    send(32'h402081B3, 32'h1004);
    chk("sub_funct7", {95'd0, out_alu_funct7}, 96'd1);
    send(32'hFFF00093, 32'h1008);
    chk("addi_fields", {59'd0, out_opclass, out_imm, out_alu_funct7}, {59'd0, 4'd1, 32'hFFFF_FFFF, 1'b0});
    send(32'h00812283, 32'h100C);
    chk("lw_fields", {54'd0, out_opclass, out_alu_funct3, out_funct3_raw, out_imm}, {54'd0, 4'd2, 3'd0, 3'd2, 32'd8});
    send(32'h002091B3, 32'h1010);
    chk("sll_illegal", {88'd0, out_illegal, out_opclass, out_reg_write, out_alu_funct3}, {88'd0, 1'b1, 4'd15, 1'b0, 3'd0});
    send(32'h0000007F, 32'h1014);
    chk("op7f_illegal", {88'd0, out_illegal, out_opclass, out_reg_write, out_alu_funct3}, {88'd0, 1'b1, 4'd15, 1'b0, 3'd0});
    send(32'h008000EF, 32'h1018);
    chk("jal_imm_rd", {59'd0, out_imm, out_rd}, {59'd0, 32'd8, 5'd1});
    send(32'h123452B7, 32'h101C);
    chk("lui_imm", {59'd0, out_imm, out_rd}, {59'd0, 32'h1234_5000, 5'd5});
    for (int n = 0; n < 12; n++) send(words[n], 32'h2000 + 32'(n * 4));
    cyc(acc);

    drained.delete();
    idx = 0; k = 0;
    while ((idx < 4 || out_valid) && k < 30) begin
      in_valid  = (idx < 4);
      in_instr  = stream[idx < 4 ? idx : 3];
      in_pc     = 32'h3000 + 32'(idx * 4);
      out_ready = !(k >= 2 && k <= 4);
      if (k >= 2 && k <= 4) begin
        #1;
        chk("hold_in_ready", {95'd0, in_ready}, 96'd0);
      end
      cyc(acc);
      if (acc) idx++;
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_within_budget", {95'd0, k < 30}, 96'd1);
    chk("stream_drain_count", 96'(drained.size()), 96'd4);
    for (int n = 0; n < 4; n++)
      if (n < drained.size()) chk("stream_order", {64'd0, drained[n]}, {64'd0, 32'h3000 + 32'(n * 4)});
    chk("stream_cycles", 96'(k), 96'd8);

    in_valid = 1'b1; in_instr = 32'h0020C1B3; in_pc = 32'h4000; out_ready = 1'b0;
    cyc(acc);
    chk("flush_pre_valid", {95'd0, out_valid}, 96'd1);
    in_instr = 32'h0020E1B3; in_pc = 32'h4004; flush = 1'b1;
    #1;
    chk("flush_in_ready", {95'd0, in_ready}, 96'd0);
    cyc(acc);
    chk("flush_no_accept", {95'd0, acc}, 96'd0);
    chk("flush_valid_dropped", {95'd0, out_valid}, 96'd0);
    flush = 1'b0; in_instr = 32'h0020F1B3; in_pc = 32'h4008; out_ready = 1'b1;
    cyc(acc);
    in_valid = 1'b0;
    chk("after_flush_valid", {95'd0, out_valid}, 96'd1);
    chk("after_flush_pc", {64'd0, out_pc}, {64'd0, 32'h4008});
    repeat (3) cyc(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
